// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS opcode constants, register-usage helpers and decode FSM states
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } state_e;

    // Destination 0 doubles as "no architectural write".
    function automatic logic [4:0] dest_of(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == OP_RTYPE)                    return instr[15:11];
        else if (op[5:3] == 3'b001 || op == OP_LW) return instr[20:16];
        else if (op == OP_JAL)                 return 5'd31;
        else                                   return 5'd0;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL || op == OP_LUI);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    endfunction

endpackage

// File: rtl/decode_nway_if.sv
// rtl/decode_nway_if.sv - fetch, writeback and execute-side signals of the N-way decode stage
interface decode_nway_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int XLEN        = 32,
    parameter int NREGS       = 32
);
    localparam int RW = $clog2(NREGS);

    logic                        in_valid;
    logic                        in_ready;
    logic [ISSUE_WIDTH*XLEN-1:0] in_instr;
    logic [ISSUE_WIDTH*XLEN-1:0] in_pc4;
    logic [ISSUE_WIDTH-1:0]      wr_en;
    logic [ISSUE_WIDTH*RW-1:0]   wr_addr;
    logic [ISSUE_WIDTH*XLEN-1:0] wr_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [ISSUE_WIDTH-1:0]      out_slot_valid;
    logic [ISSUE_WIDTH*6-1:0]    out_opcode;
    logic [ISSUE_WIDTH*6-1:0]    out_funct;
    logic [ISSUE_WIDTH*RW-1:0]   out_rt;
    logic [ISSUE_WIDTH*RW-1:0]   out_rd;
    logic [ISSUE_WIDTH*RW-1:0]   out_shamt;
    logic [ISSUE_WIDTH*RW-1:0]   out_dest;
    logic [ISSUE_WIDTH*XLEN-1:0] out_imm;
    logic [ISSUE_WIDTH*XLEN-1:0] out_jaddr;
    logic [ISSUE_WIDTH*XLEN-1:0] out_a;
    logic [ISSUE_WIDTH*XLEN-1:0] out_b;

    modport master (
        output in_valid, in_instr, in_pc4, wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_slot_valid, out_opcode, out_funct, out_rt, out_rd,
               out_shamt, out_dest, out_imm, out_jaddr, out_a, out_b
    );

    modport slave (
        input  in_valid, in_instr, in_pc4, wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_slot_valid, out_opcode, out_funct, out_rt, out_rd,
               out_shamt, out_dest, out_imm, out_jaddr, out_a, out_b
    );
endinterface

// File: rtl/regfile_nw.sv
// rtl/regfile_nw.sv - multi-port register file, r0 hardwired to zero, same-cycle write bypass
module regfile_nw #(
    parameter int NPORTS = 2,
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPORTS-1:0]          wr_en_i,
    input  logic [NPORTS*RW-1:0]       wr_addr_i,
    input  logic [NPORTS*XLEN-1:0]     wr_data_i,
    input  logic [2*NPORTS*RW-1:0]     rd_addr_i,
    output logic [2*NPORTS*XLEN-1:0]   rd_data_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Later ports are applied last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++)
                if (wr_en_i[p] && wr_addr_i[p*RW +: RW] != '0)
                    regs_q[wr_addr_i[p*RW +: RW]] <= wr_data_i[p*XLEN +: XLEN];
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < 2*NPORTS; r++) begin
            if (rd_addr_i[r*RW +: RW] != '0) begin
                rd_data_o[r*XLEN +: XLEN] = regs_q[rd_addr_i[r*RW +: RW]];
                for (int p = 0; p < NPORTS; p++)
                    if (wr_en_i[p] && wr_addr_i[p*RW +: RW] == rd_addr_i[r*RW +: RW])
                        rd_data_o[r*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/decode_nway.sv
// rtl/decode_nway.sv - N-way MIPS decode stage: field decode, operand read, RAW bundle split, output register
module decode_nway import decode_pkg::*; #(
    parameter int ISSUE_WIDTH = 2,
    parameter int XLEN        = 32,
    parameter int NREGS       = 32
) (
    input logic         clk,
    input logic         reset,
    decode_nway_if.slave io
);
    localparam int IW = ISSUE_WIDTH;
    localparam int RW = $clog2(NREGS);

    state_e               state_q, state_d;
    logic [IW*XLEN-1:0]   pend_instr_q, pend_instr_d;
    logic [IW*4-1:0]      pend_pc4hi_q, pend_pc4hi_d;
    logic [IW-1:0]        pend_live_q, pend_live_d;

    logic [IW*XLEN-1:0]   cand_instr;
    logic [IW*4-1:0]      cand_pc4hi, in_pc4hi;
    logic [IW-1:0]        cand_live;
    logic                 pc4_unused;

    logic [IW*6-1:0]      op_f, funct_f;
    logic [IW*RW-1:0]     rs_f, rt_f, rd_f, shamt_f, dest_f;
    logic [IW*XLEN-1:0]   imm_f, jaddr_f, a_data, b_data;
    logic [IW-1:0]        use_rs, use_rt, conflict, issue_mask;
    logic [XLEN-1:0]      w;
    logic                 split, advance, fire;
    int                   kstar;

    logic                 out_valid_q;
    logic [IW-1:0]        slot_valid_q;
    logic [IW*6-1:0]      opcode_q, funct_q;
    logic [IW*RW-1:0]     rt_q, rd_q, shamt_q, dest_q;
    logic [IW*XLEN-1:0]   imm_q, jaddr_q, a_q, b_q;

    // Only the top nibble of PC+4 feeds the jump target.
    assign pc4_unused = ^io.in_pc4;
    always_comb begin
        in_pc4hi = '0;
        for (int s = 0; s < IW; s++) in_pc4hi[s*4 +: 4] = io.in_pc4[s*XLEN + XLEN - 4 +: 4];
    end

    always_comb begin
        if (state_q == RUN) begin
            cand_instr = io.in_instr;
            cand_pc4hi = in_pc4hi;
            cand_live  = '1;
        end else begin
            cand_instr = pend_instr_q;
            cand_pc4hi = pend_pc4hi_q;
            cand_live  = pend_live_q;
        end
    end

    always_comb begin
        w = '0;
        for (int s = 0; s < IW; s++) begin
            w = cand_instr[s*XLEN +: XLEN];
            op_f[s*6 +: 6]        = w[31:26];
            funct_f[s*6 +: 6]     = w[5:0];
            rs_f[s*RW +: RW]      = RW'(w[25:21]);
            rt_f[s*RW +: RW]      = RW'(w[20:16]);
            rd_f[s*RW +: RW]      = RW'(w[15:11]);
            shamt_f[s*RW +: RW]   = RW'(w[10:6]);
            dest_f[s*RW +: RW]    = RW'(dest_of(w[31:0]));
            imm_f[s*XLEN +: XLEN] = {{(XLEN-16){w[15]}}, w[15:0]};
            jaddr_f[s*XLEN +: XLEN] = {cand_pc4hi[s*4 +: 4], w[25:0], 2'b00};
            use_rs[s]             = uses_rs(w[31:26]);
            use_rt[s]             = uses_rt(w[31:26]);
        end
    end

    regfile_nw #(.NPORTS(IW), .XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (io.wr_en),
        .wr_addr_i (io.wr_addr),
        .wr_data_i (io.wr_data),
        .rd_addr_i ({rt_f, rs_f}),
        .rd_data_o ({b_data, a_data})
    );

    always_comb begin
        conflict = '0;
        for (int k = 1; k < IW; k++)
            for (int j = 0; j < k; j++)
                if (cand_live[j] && cand_live[k] && dest_f[j*RW +: RW] != '0 &&
                    ((use_rs[k] && dest_f[j*RW +: RW] == rs_f[k*RW +: RW]) ||
                     (use_rt[k] && dest_f[j*RW +: RW] == rt_f[k*RW +: RW])))
                    conflict[k] = 1'b1;
    end

    // kstar == IW means the whole candidate set issues.
    always_comb begin
        kstar = IW;
        for (int k = IW - 1; k >= 1; k--) if (conflict[k]) kstar = k;
        split      = |conflict;
        issue_mask = cand_live;
        for (int k = 0; k < IW; k++) if (k >= kstar) issue_mask[k] = 1'b0;
    end

    assign advance     = ~out_valid_q | io.out_ready;
    assign io.in_ready = (state_q == RUN) & advance;
    assign fire        = advance & ((state_q == RUN) ? io.in_valid : 1'b1);

    // Remaining slots are packed down to slot 0 so the next issue starts there.
    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        pend_pc4hi_d = pend_pc4hi_q;
        pend_live_d  = pend_live_q;
        if (fire) begin
            state_d      = split ? SPLIT : RUN;
            pend_instr_d = '0;
            pend_pc4hi_d = '0;
            pend_live_d  = '0;
            for (int i = 0; i < IW; i++)
                for (int k = 0; k < IW; k++)
                    if (k == i + kstar) begin
                        pend_instr_d[i*XLEN +: XLEN] = cand_instr[k*XLEN +: XLEN];
                        pend_pc4hi_d[i*4 +: 4]       = cand_pc4hi[k*4 +: 4];
                        pend_live_d[i]               = cand_live[k];
                    end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pend_instr_q <= '0;
            pend_pc4hi_q <= '0;
            pend_live_q  <= '0;
            out_valid_q  <= 1'b0;
            slot_valid_q <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            shamt_q      <= '0;
            dest_q       <= '0;
            imm_q        <= '0;
            jaddr_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
            pend_pc4hi_q <= pend_pc4hi_d;
            pend_live_q  <= pend_live_d;
            if (advance) begin
                out_valid_q <= fire;
                if (fire) begin
                    slot_valid_q <= issue_mask;
                    opcode_q     <= op_f;
                    funct_q      <= funct_f;
                    rt_q         <= rt_f;
                    rd_q         <= rd_f;
                    shamt_q      <= shamt_f;
                    dest_q       <= dest_f;
                    imm_q        <= imm_f;
                    jaddr_q      <= jaddr_f;
                    a_q          <= a_data;
                    b_q          <= b_data;
                end
            end
        end
    end

    assign io.out_valid      = out_valid_q;
    assign io.out_slot_valid = slot_valid_q;
    assign io.out_opcode     = opcode_q;
    assign io.out_funct      = funct_q;
    assign io.out_rt         = rt_q;
    assign io.out_rd         = rd_q;
    assign io.out_shamt      = shamt_q;
    assign io.out_dest       = dest_q;
    assign io.out_imm        = imm_q;
    assign io.out_jaddr      = jaddr_q;
    assign io.out_a          = a_q;
    assign io.out_b          = b_q;

endmodule

// File: doc/decode_nway.md
# decode_nway

Parametrised N-way decode stage for the superscalar MIPS pipeline, sitting between fetch and execute. It accepts a bundle of `ISSUE_WIDTH` instruction words and decodes the fields, immediates and jump targets. It reads operands from an internal multi-write-port register file with same-cycle write bypass. It splits any bundle that contains an intra-bundle read-after-write dependency, issuing it over successive cycles, and presents a registered bundle to execute under a ready/valid handshake.

## Interface
Parameters:
- `ISSUE_WIDTH`, default 2: slots per bundle, range 1–4.
- `XLEN`, default 32: data and instruction width.
- `NREGS`, default 32: number of architectural registers; index width is `RW = $clog2(NREGS)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch bundle valid.
- `in_ready` out 1: stage accepts a bundle this cycle.
- `in_instr` in `ISSUE_WIDTH*XLEN`: instruction words; slot 0 is the oldest.
- `in_pc4` in `ISSUE_WIDTH*XLEN`: PC+4 of each slot.
- `wr_en` in `ISSUE_WIDTH`: writeback enable per port.
- `wr_addr` in `ISSUE_WIDTH*RW`: writeback register index per port.
- `wr_data` in `ISSUE_WIDTH*XLEN`: writeback data per port.
- `out_valid` out 1: registered bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_slot_valid` out `ISSUE_WIDTH`: mask of slots that are live in the bundle.
- `out_opcode` out `ISSUE_WIDTH*6`: opcode per slot.
- `out_funct` out `ISSUE_WIDTH*6`: funct field per slot.
- `out_rt`, `out_rd`, `out_shamt`, `out_dest` out `ISSUE_WIDTH*RW` each: decoded register fields and destination index per slot.
- `out_imm` out `ISSUE_WIDTH*XLEN`: sign-extended immediate per slot.
- `out_jaddr` out `ISSUE_WIDTH*XLEN`: jump target per slot.
- `out_a`, `out_b` out `ISSUE_WIDTH*XLEN` each: rs and rt operand data per slot.

## Operation
- **Field decode:** opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- **Immediate and jump target:**
  - `imm` = sign-extension of [15:0].
  - `jaddr` = {pc4[31:28], instr[25:0], 2'b00}.
- **Destination register (`dest`):**
  - opcode 0x00 gives rd.
  - Opcodes 0x08–0x0F and 0x23 give rt.
  - 0x03 (jal) gives 31.
  - All other opcodes give 0, meaning no write.
- **Register usage:**
  - `uses_rs` is true for every opcode except 0x02, 0x03 and 0x0F.
  - `uses_rt` is true for opcodes 0x00, 0x04, 0x05 and 0x2B.
- **Hazard check:** slot k conflicts if, for some live older slot j<k in the same bundle, dest_j≠0 and dest_j equals either rs_k (with `uses_rs`) or rt_k (with `uses_rt`). k* is the lowest conflicting slot.
- **Register file:**
  - Register 0 always reads as 0 and ignores writes.
  - Writes land at the clock edge.
  - Simultaneous writes to the same index: the highest-numbered port wins.
  - A read whose index matches a same-cycle `wr_en` port returns `wr_data`, with the highest-numbered matching port winning.
  - Reset clears all registers to 0.
- **FSM states:**
  - **RUN:**
    - `in_ready` = `advance`, where `advance = ~out_valid | out_ready`.
    - On accept with no conflict, all slots issue.
    - On accept with a conflict, slots 0..k*-1 issue, slots k*..N-1 are copied into the pending buffer, and the FSM moves to SPLIT.
  - **SPLIT:**
    - `in_ready` = 0.
    - On `advance`, the pending slots are re-decoded, re-checked for conflicts and issued in original order, packed starting at slot 0.
    - If a conflict remains, the FSM stays in SPLIT with a new pending set; otherwise it returns to RUN.
- **Output register:**
  - Loads on `advance` when a bundle issues.
  - On `advance` with nothing issued, `out_valid` goes to 0.
  - While `out_valid & ~out_ready`, every output holds stable.

## Timing
- Latency is 1 cycle: an accept at edge n gives `out_valid` after edge n.
- Full throughput: one bundle per cycle when there are no conflicts and no backpressure.
- A bundle split m times occupies m+1 output cycles.
- Operands are sampled in the issue cycle. A write in that same cycle is visible through the bypass; a write one cycle earlier is visible through the register file.
- **Reset:**
  - State returns to RUN and the pending buffer is cleared.
  - `out_valid` = 0 and `out_slot_valid` = 0.
  - All data outputs are 0; `in_ready` = 1.
  - A reset while in SPLIT discards the pending slots.
- **Backpressure:** `in_valid` held with `in_ready` = 0 is not consumed, and the source must hold its bundle stable.

## Structure
- Package `decode_pkg`:
  - Opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LUI, OP_LW, OP_SW.
  - Functions `dest_of`, `uses_rs`, `uses_rt`.
  - State enum {RUN, SPLIT}.
- Sub-module `regfile_nw`: `NREGS` entries, 2·`ISSUE_WIDTH` read ports and `ISSUE_WIDTH` write ports, write bypass, synchronous reset.
- Top-level `decode_nway` holds the per-slot decode loop, the hazard priority encoder, the FSM, the pending buffer and the output register.

## Test plan
- **Basic decode:** after reset, write r3=0x0000_00AA; issue bundle {addi r1,r3,-1 (0x2061FFFF), j 0x40 (0x08000010)} with pc4=0x1000_0004/0x1000_0008 → next cycle `slot_valid`=2'b11, a0=0xAA, imm0=0xFFFF_FFFF, dest0=1, jaddr1=0x1000_0040.
- **Split:** bundle {addi r2,r0,5 ; add r4,r2,r2} → cycle 1 `slot_valid`=01 with `in_ready`=0; cycle 2 `slot_valid`=01 holds the add with dest=4; cycle 3 `in_ready`=1.
- **Write bypass:** `wr_en`[0]=1, r5←0x1234 in the same cycle as accepting `or r6,r5,r0` → a0=0x1234; with both ports writing r5, port 1 value wins.
- **Backpressure:** `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0; release → the next bundle is accepted on the same edge.
- **r0 rule:** a bundle where `addi r0,…` is followed by a reader of r0 does not split; a write to r0 is ignored and a0 reads 0.
- **Reset in SPLIT:** assert `reset` during SPLIT (`ISSUE_WIDTH`=4 with conflict at slot 1) → next cycle `out_valid`=0, `in_ready`=1, pending slots never appear on the output.
